// File: rtl/simplebus_fifo.sv
`default_nettype none
// ============================================================================
// Module      : simplebus_fifo
// Description : Parametrised valid/ready buffering stage for the simplebus
//               "foo" payload. It holds DEPTH entries of WIDTH bits in a
//               circular array and adds occupancy reporting, a synchronous
//               flush and a sticky flag for offers dropped while full.
//
// Ports       : clk           - single clock, rising edge
//               reset         - synchronous, active-high; highest priority
//               flush         - synchronous discard of all stored entries
//               in_valid      - producer offers in_foo
//               in_ready      - FIFO can accept this cycle (from state only)
//               in_foo        - producer payload, sampled only on push
//               out_valid     - out_foo holds the oldest entry
//               out_ready     - consumer takes out_foo this cycle
//               out_foo       - oldest stored payload, forced to 0 when empty
//               count         - stored entries, 0..DEPTH
//               err_push_full - sticky: in_valid seen while in_ready low
//
// Revision    : 1.0 - initial release
// ============================================================================
module simplebus_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_foo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_foo,
    output logic [CW-1:0]    count,
    output logic             err_push_full
);

    localparam int                 c_pw       = $clog2(DEPTH);
    localparam logic [c_pw-1:0]    c_ptr_last = c_pw'(DEPTH - 1);
    localparam logic [c_pw-1:0]    c_ptr_one  = c_pw'(1);
    localparam logic [CW-1:0]      c_full     = CW'(DEPTH);
    localparam logic [CW-1:0]      c_cnt_one  = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wp;
    logic [c_pw-1:0]  r_rp;
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_one;
    endfunction

    // Ready is derived from occupancy alone: no path from out_ready, so a
    // full FIFO cannot accept a word even in a cycle where it is popped.
    assign w_in_ready  = (r_cnt != c_full);
    assign w_out_valid = (r_cnt != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    // Mask keeps stale, unreset storage invisible while empty.
    assign out_foo       = w_out_valid ? r_mem[r_rp] : '0;
    assign count         = r_cnt;
    assign err_push_full = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // A dropped offer is recorded even during a flush cycle.
            if (in_valid && !w_in_ready) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= f_next(r_wp);
                end
                if (w_pop) begin
                    r_rp <= f_next(r_rp);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
            end
        end
    end

    // Storage has no reset; contents are only observable through out_foo.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wp] <= in_foo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simplebus_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_simplebus_fifo
// Description : Self-checking bench for simplebus_fifo. Two lanes run side by
//               side: lane 0 (WIDTH=3, DEPTH=4) receives directed sequences
//               followed by random traffic, lane 1 (WIDTH=3, DEPTH=5) receives
//               random traffic throughout. Each lane keeps a queue-based
//               reference model and a monitor that pops expected words when
//               the DUT hands one over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simplebus_fifo;

    logic       clk;
    logic       reset;
    logic [1:0] flush_v;
    logic [1:0] in_valid_v;
    logic [1:0] out_ready_v;
    logic [2:0] in_foo_v [2];

    int checks;
    int errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int D  = (gi == 0) ? 4 : 5;
        localparam int CW = $clog2(D + 1);

        logic          in_ready_o;
        logic          out_valid_o;
        logic [2:0]    out_foo_o;
        logic [CW-1:0] count_o;
        logic          err_o;

        simplebus_fifo #(.WIDTH(3), .DEPTH(D)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .flush         (flush_v[gi]),
            .in_valid      (in_valid_v[gi]),
            .in_ready      (in_ready_o),
            .in_foo        (in_foo_v[gi]),
            .out_valid     (out_valid_o),
            .out_ready     (out_ready_v[gi]),
            .out_foo       (out_foo_o),
            .count         (count_o),
            .err_push_full (err_o)
        );

        // Reference model: a queue of words in flight plus an occupancy
        // number that follows the accept/deliver rules cycle by cycle.
        logic [2:0] exp_q [$];
        int         m_cnt = 0;
        bit         m_err = 1'b0;

        always @(posedge clk) begin
            bit acc;
            bit del;
            if (reset) begin
                m_cnt = 0;
                m_err = 1'b0;
                exp_q.delete();
            end else begin
                if (in_valid_v[gi] && m_cnt == D) m_err = 1'b1;
                if (flush_v[gi]) begin
                    m_cnt = 0;
                    exp_q.delete();
                end else begin
                    acc = in_valid_v[gi] && (m_cnt < D);
                    del = out_ready_v[gi] && (m_cnt > 0);
                    if (acc) exp_q.push_back(in_foo_v[gi]);
                    m_cnt = m_cnt + int'(acc) - int'(del);
                end
            end
        end

        // Monitor: status checks mid-cycle, then consume the expected word
        // whenever the DUT completes an output handshake at the next edge.
        always @(negedge clk) begin
            logic [2:0] e;
            chk($sformatf("lane%0d count", gi), 32'(count_o), 32'(m_cnt));
            chk($sformatf("lane%0d count_le_depth", gi), 32'(int'(count_o) <= D), 32'd1);
            chk($sformatf("lane%0d in_ready", gi), 32'(in_ready_o), 32'(m_cnt != D));
            chk($sformatf("lane%0d out_valid", gi), 32'(out_valid_o), 32'(m_cnt != 0));
            chk($sformatf("lane%0d err_push_full", gi), 32'(err_o), 32'(m_err));
            if (m_cnt == 0) begin
                chk($sformatf("lane%0d out_foo_empty", gi), 32'(out_foo_o), 32'd0);
            end
            if (out_valid_o === 1'b1 && out_ready_v[gi] && !reset && !flush_v[gi]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("lane%0d pop_without_data", gi), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("lane%0d out_foo", gi), 32'(out_foo_o), 32'(e));
                end
            end
        end
    end

    // Advance one cycle; lane 1 always gets fresh random stimulus, lane 0
    // only when rand0 is set. Inputs change 1 time unit after the edge.
    task automatic tick(input bit rand0 = 1'b0);
        in_valid_v[1]  = 1'($urandom);
        out_ready_v[1] = 1'($urandom);
        in_foo_v[1]    = 3'($urandom);
        flush_v[1]     = ($urandom_range(0, 31) == 0);
        if (rand0) begin
            in_valid_v[0]  = 1'($urandom);
            out_ready_v[0] = ($urandom_range(0, 3) != 0);
            in_foo_v[0]    = 3'($urandom);
            flush_v[0]     = ($urandom_range(0, 47) == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        flush_v[0]     = 1'b0;
        in_foo_v[0]    = 3'd0;
    endtask

    task automatic push0(input logic [2:0] d);
        in_valid_v[0] = 1'b1;
        in_foo_v[0]   = d;
        tick();
        in_valid_v[0] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle0();
        flush_v[1] = 1'b0; in_valid_v[1] = 1'b0; out_ready_v[1] = 1'b0; in_foo_v[1] = 3'd0;
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();

        // Three pushes, then drain in order.
        push0(3'h5); push0(3'h2); push0(3'h7);
        out_ready_v[0] = 1'b1;
        repeat (4) tick();
        idle0();

        // Fill, then one dropped offer while full, then drain.
        for (int i = 0; i < 4; i++) push0(3'(i + 3));
        in_valid_v[0] = 1'b1; in_foo_v[0] = 3'h1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        out_ready_v[0] = 1'b1;
        repeat (5) tick();
        idle0();

        // Sustained push+pop at occupancy 2, walking the pointers round.
        push0(3'h0); push0(3'h1);
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_foo_v[0] = 3'(i + 2);
            tick();
        end
        in_valid_v[0] = 1'b0;
        repeat (3) tick();
        idle0();

        // Flush at occupancy 3 together with an offered word.
        push0(3'h3); push0(3'h4); push0(3'h6);
        flush_v[0] = 1'b1; in_valid_v[0] = 1'b1; in_foo_v[0] = 3'h2;
        tick();
        idle0();
        tick();

        // Reset mid-stream at occupancy 2, then first push after reset.
        push0(3'h1); push0(3'h6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        push0(3'h4);
        out_ready_v[0] = 1'b1;
        repeat (2) tick();
        idle0();

        // Random traffic on both lanes with occasional reset.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            tick(1'b1);
        end
        reset = 1'b0;
        idle0();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
